// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the memory responder.
// Holds the FSM state encoding, the latency ceiling and the alignment rule.
// Build option: MEM_RESP_ERR_EN enables the request checker that uses mem_resp_misaligned.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_resp_state_t;

    localparam int MEM_RESP_MAX_LATENCY = 15;
    localparam int MEM_RESP_CNT_W       = $clog2(MEM_RESP_MAX_LATENCY + 1);

    // A two-lane mask needs an even address; a four-lane mask needs a word-aligned address.
    // Single-lane and irregular masks are always considered aligned.
    function automatic logic mem_resp_misaligned(input logic [3:0] mask, input logic [1:0] lo);
        logic half;
        logic full;
        half = (mask == 4'b0011) || (mask == 4'b1100);
        full = (mask == 4'b1111);
        return (half && lo[0]) || (full && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between a CPU memory port and mem_responder.
// master = requester side, slave = responder side.
// Build option: MEM_RESP_ERR_EN adds the err response signal.
interface mem_responder_if;

    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        resp;
`ifdef MEM_RESP_ERR_EN
    logic        err;

    modport master (output addr, rmask, wmask, wdata, input rdata, resp, err);
    modport slave  (input addr, rmask, wmask, wdata, output rdata, resp, err);
`else
    modport master (output addr, rmask, wmask, wdata, input rdata, resp);
    modport slave  (input addr, rmask, wmask, wdata, output rdata, resp);
`endif

endinterface

// File: rtl/mem_resp_array.sv
// Word-addressed 32-bit storage with per-byte write enables and read-before-write.
// Latency: write lands and the pre-write word is registered on the same clock edge.
// Backpressure: none; the owner issues at most one access per cycle.
module mem_resp_array #(
    parameter int DEPTH_WORDS = 4096,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] idx,
    input  logic             rd_en,
    input  logic             rd_clr,
    input  logic [3:0]       wr_be,
    input  logic [31:0]      wr_data,
    output logic [31:0]      rd_data
);

    logic [31:0] mem [DEPTH_WORDS];

    // Byte-lane writes; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
                mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Output register samples the old word, and holds it until the next read or clear.
    always_ff @(posedge clk) begin
        if (rst || rd_clr) begin
            rd_data <= 32'd0;
        end else if (rd_en) begin
            rd_data <= mem[idx];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Single-request memory responder: latches a request, waits, accesses the array, pulses resp.
// Latency: resp exactly LATENCY cycles after acceptance; next request taken LATENCY+1 after.
// Backpressure: none; inputs are ignored while busy. Build option MEM_RESP_ERR_EN adds err.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 2
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);

    localparam int                        IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [MEM_RESP_CNT_W-1:0] LAT_M1 = MEM_RESP_CNT_W'(LATENCY - 1);

    mem_resp_state_t             state;
    mem_resp_state_t             state_nxt;
    logic [MEM_RESP_CNT_W-1:0]   cnt;
    logic [31:0]                 addr_q;
    logic [31:0]                 wdata_q;
    logic [3:0]                  rmask_q;
    logic [3:0]                  wmask_q;
    logic                        err_q;

    logic                        req;
    logic                        accept;
    logic                        access;
    logic [31:0]                 acc_addr;
    logic [31:0]                 acc_wdata;
    logic [3:0]                  acc_rmask;
    logic [3:0]                  acc_wmask;
    logic                        acc_err;
    logic [31:0]                 rd_word;

    assign req = (bus.rmask | bus.wmask) != 4'd0;

    // With LATENCY=1 the access happens on the accept edge itself, so the operands
    // come straight from the bus; otherwise they come from the latched copy.
    assign acc_addr  = (state == IDLE) ? bus.addr  : addr_q;
    assign acc_wdata = (state == IDLE) ? bus.wdata : wdata_q;
    assign acc_rmask = (state == IDLE) ? bus.rmask : rmask_q;
    assign acc_wmask = (state == IDLE) ? bus.wmask : wmask_q;

`ifdef MEM_RESP_ERR_EN
    assign acc_err = (acc_addr[31:IDX_W+2] != '0) ||
                     mem_resp_misaligned(acc_rmask | acc_wmask, acc_addr[1:0]);
`else
    logic unused_addr_bits;
    assign acc_err          = 1'b0;
    assign unused_addr_bits = ^{acc_addr[31:IDX_W+2], acc_addr[1:0]};
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: WAIT lasts LATENCY-1 cycles, the access fires on the edge leaving it.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        access    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        access    = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == MEM_RESP_CNT_W'(1)) begin
                    access    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: resp (and err) only in the RESP cycle.
    always_comb begin
        bus.resp = (state == RESP);
`ifdef MEM_RESP_ERR_EN
        bus.err  = (state == RESP) && err_q;
`endif
    end

    // Request latch, counter of WAIT cycles left, and error flag for the pending response.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rmask_q <= '0;
            wmask_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                cnt     <= LAT_M1;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
                rmask_q <= bus.rmask;
                wmask_q <= bus.wmask;
            end else if (state == WAIT) begin
                cnt <= cnt - MEM_RESP_CNT_W'(1);
            end
            if (access) begin
                err_q <= acc_err;
            end
        end
    end

    // A reset on the access edge must not corrupt the array, hence the rst gate on writes.
    mem_resp_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .idx     (acc_addr[IDX_W+1:2]),
        .rd_en   (access && (acc_rmask != 4'd0)),
        .rd_clr  (access && acc_err),
        .wr_be   ((access && !acc_err && !rst) ? acc_wmask : 4'd0),
        .wr_data (acc_wdata),
        .rd_data (rd_word)
    );

    assign bus.rdata = rd_word;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a LATENCY=2 and a LATENCY=1 instance share one stimulus bus.
// A cycle-level reference model (absolute response cycle + word array) is compared every cycle.
// Directed cases pin literal values; a random phase exercises resets, holds, wrap and masks.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  rmask;
    logic [3:0]  wmask;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder_if ifa ();
    mem_responder_if ifb ();

    assign ifa.addr  = addr;
    assign ifa.rmask = rmask;
    assign ifa.wmask = wmask;
    assign ifa.wdata = wdata;
    assign ifb.addr  = addr;
    assign ifb.rmask = rmask;
    assign ifb.wmask = wmask;
    assign ifb.wdata = wdata;

    mem_responder #(.DEPTH_WORDS(4096), .LATENCY(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    mem_responder #(.DEPTH_WORDS(4096), .LATENCY(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    int errors = 0;
    int checks = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mmem   [2][4096];
    bit          pend   [2];
    int          rcyc   [2];
    logic [31:0] p_addr [2];
    logic [31:0] p_wdata[2];
    logic [3:0]  p_rm   [2];
    logic [3:0]  p_wm   [2];
    logic [31:0] e_rdata[2];
    bit          e_resp [2];
    bit          e_err  [2];

    function automatic int lat(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic bit req_is_bad(input logic [31:0] a, input logic [3:0] m);
        bit bad;
        bad = (a >= 32'h0000_4000) ||
              (((m == 4'b0011) || (m == 4'b1100)) && a[0]) ||
              ((m == 4'b1111) && (a[1:0] != 2'b00));
`ifndef MEM_RESP_ERR_EN
        bad = 1'b0;
`endif
        return bad;
    endfunction

    task automatic model_access(input int d);
        int idx;
        bit bad;
        idx = int'(p_addr[d] >> 2) % 4096;
        bad = req_is_bad(p_addr[d], p_rm[d] | p_wm[d]);
        e_err[d] = bad;
        if (bad) begin
            e_rdata[d] = 32'd0;
        end else begin
            if (p_rm[d] != 4'd0) e_rdata[d] = mmem[d][idx];
            for (int i = 0; i < 4; i++)
                if (p_wm[d][i]) mmem[d][idx][8*i +: 8] = p_wdata[d][8*i +: 8];
        end
    endtask

    // Called at the end of cycle k with the inputs sampled at the closing edge; yields cycle k+1.
    task automatic model_step(input int d, input int k);
        if (rst) begin
            pend[d]    = 1'b0;
            e_rdata[d] = 32'd0;
            e_err[d]   = 1'b0;
        end else if (pend[d]) begin
            if (k == rcyc[d]) pend[d] = 1'b0;
            else if (k + 1 == rcyc[d]) model_access(d);
        end else if ((rmask | wmask) != 4'd0) begin
            pend[d]    = 1'b1;
            rcyc[d]    = k + lat(d);
            p_addr[d]  = addr;
            p_wdata[d] = wdata;
            p_rm[d]    = rmask;
            p_wm[d]    = wmask;
            if (k + 1 == rcyc[d]) model_access(d);
        end
        e_resp[d] = pend[d] && (k + 1 == rcyc[d]);
    endtask

    // Compare process: every cycle after the first reset edge.
    initial begin
        for (int d = 0; d < 2; d++) begin
            pend[d] = 1'b0; e_rdata[d] = 32'd0; e_resp[d] = 1'b0; e_err[d] = 1'b0; rcyc[d] = 0;
        end
        @(posedge clk iff rst === 1'b1);
        forever begin
            @(negedge clk);
            check32("a_resp",  {31'd0, ifa.resp}, {31'd0, e_resp[0]});
            check32("a_rdata", ifa.rdata, e_rdata[0]);
            check32("b_resp",  {31'd0, ifb.resp}, {31'd0, e_resp[1]});
            check32("b_rdata", ifb.rdata, e_rdata[1]);
`ifdef MEM_RESP_ERR_EN
            check32("a_err", {31'd0, ifa.err}, {31'd0, e_resp[0] && e_err[0]});
            check32("b_err", {31'd0, ifb.err}, {31'd0, e_resp[1] && e_err[1]});
`endif
            model_step(0, cyc);
            model_step(1, cyc);
        end
    end

    // ---------------- stimulus ----------------
    int last_la;
    int last_lb;
    bit last_ea;

    // Drive one request for one cycle, then idle long enough for both instances to finish.
    task automatic do_req(input logic [31:0] a, input logic [3:0] r, input logic [3:0] w,
                          input logic [31:0] d);
        int t0;
        addr = a; rmask = r; wmask = w; wdata = d;
        t0 = cyc; last_la = -1; last_lb = -1; last_ea = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ifa.resp && last_la < 0) last_la = cyc - t0;
            if (ifb.resp && last_lb < 0) last_lb = cyc - t0;
`ifdef MEM_RESP_ERR_EN
            if (ifa.resp && ifa.err) last_ea = 1'b1;
`endif
            @(posedge clk); #1;
            rmask = 4'd0; wmask = 4'd0;
        end
    endtask

    function automatic logic [3:0] pick_mask();
        logic [3:0] m;
        case ($urandom_range(0, 7))
            0: m = 4'b0001;
            1: m = 4'b0100;
            2: m = 4'b0011;
            3: m = 4'b1100;
            4, 5: m = 4'b1111;
            default: m = 4'($urandom_range(1, 15));
        endcase
        return m;
    endfunction

    function automatic logic [31:0] pick_addr();
        int k;
        logic [11:0] idx;
        logic [17:0] hi;
        k   = $urandom_range(0, 17);
        idx = (k < 16) ? 12'(k) : ((k == 16) ? 12'h040 : 12'h080);
        hi  = ($urandom_range(0, 3) == 0) ? 18'($urandom) : 18'd0;
        return {hi, idx, 2'($urandom_range(0, 3))};
    endfunction

    initial begin
        int nb;
        int dbl;
        bit prev;
        logic [11:0] pool_idx;

        rst = 1'b1; addr = '0; wdata = '0; rmask = '0; wmask = '0;
        @(posedge clk); @(negedge clk);
        check32("reset_a_resp",  {31'd0, ifa.resp}, 32'd0);
        check32("reset_a_rdata", ifa.rdata, 32'd0);
        check32("reset_b_resp",  {31'd0, ifb.resp}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Known contents for every word the bench ever reads.
        for (int i = 0; i < 18; i++) begin
            pool_idx = (i < 16) ? 12'(i) : ((i == 16) ? 12'h040 : 12'h080);
            do_req({18'd0, pool_idx, 2'b00}, 4'd0, 4'hF, 32'hA500_0000 | 32'(pool_idx));
        end

        do_req(32'h100, 4'd0, 4'hF, 32'hDEAD_BEEF);
        check32("wr_latency_a", 32'(last_la), 32'd2);
        check32("wr_latency_b", 32'(last_lb), 32'd1);
        do_req(32'h100, 4'hF, 4'd0, 32'd0);
        check32("rd_latency_a", 32'(last_la), 32'd2);
        check32("rd_word_a", ifa.rdata, 32'hDEAD_BEEF);

        do_req(32'h100, 4'd0, 4'b0100, 32'h00AA_0000);
        do_req(32'h100, 4'hF, 4'd0, 32'd0);
        check32("byte_write_a", ifa.rdata, 32'hDEAA_BEEF);
        check32("model_pin", mmem[0][12'h040], 32'hDEAA_BEEF);

        do_req(32'h100, 4'hF, 4'hF, 32'h0102_0304);
        check32("rw_prewrite_a", ifa.rdata, 32'hDEAA_BEEF);
        do_req(32'h100, 4'hF, 4'd0, 32'd0);
        check32("rw_postwrite_b", ifb.rdata, 32'h0102_0304);

`ifndef MEM_RESP_ERR_EN
        do_req(32'h0000_4004, 4'd0, 4'hF, 32'h1122_3344);
        do_req(32'h0000_0004, 4'hF, 4'd0, 32'd0);
        check32("wrap_a", ifa.rdata, 32'h1122_3344);
`else
        do_req(32'h102, 4'hF, 4'd0, 32'd0);
        check32("err_flag_a", {31'd0, last_ea}, 32'd1);
        check32("err_rdata_a", ifa.rdata, 32'd0);
        do_req(32'h4000, 4'd0, 4'hF, 32'hFFFF_FFFF);
        check32("err_wr_flag_a", {31'd0, last_ea}, 32'd1);
        do_req(32'h0, 4'hF, 4'd0, 32'd0);
        check32("err_wr_untouched_a", ifa.rdata, 32'hA500_0000);
`endif

        // Reset in the WAIT cycle of a write to 0x200 on the LATENCY=2 instance.
        do_req(32'h200, 4'd0, 4'hF, 32'h5566_7788);
        addr = 32'h200; rmask = 4'd0; wmask = 4'hF; wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        wmask = 4'd0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        nb = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ifa.resp) nb++;
            @(posedge clk); #1;
        end
        check32("rst_no_resp_a", 32'(nb), 32'd0);
        do_req(32'h200, 4'hF, 4'd0, 32'd0);
        check32("rst_no_write_a", ifa.rdata, 32'h5566_7788);

        // Continuous read requests: LATENCY=1 instance responds every other cycle.
        addr = 32'h100; rmask = 4'hF; wmask = 4'd0;
        nb = 0; dbl = 0; prev = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifb.resp) begin
                nb++;
                if (prev) dbl++;
            end
            prev = ifb.resp;
            @(posedge clk); #1;
        end
        rmask = 4'd0;
        check32("b2b_count_b", 32'(nb), 32'd10);
        check32("b2b_adjacent_b", 32'(dbl), 32'd0);
        repeat (4) begin @(posedge clk); #1; end

        // Random phase.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 149) == 0);
            case ($urandom_range(0, 3))
                0, 1: ;
                2: begin rmask = 4'd0; wmask = 4'd0; end
                default: begin
                    addr  = pick_addr();
                    wdata = $urandom;
                    rmask = ($urandom_range(0, 1) == 1) ? pick_mask() : 4'd0;
                    wmask = ($urandom_range(0, 1) == 1) ? pick_mask() : 4'd0;
                    if (rmask == 4'd0 && wmask == 4'd0) rmask = 4'hF;
                end
            endcase
            @(posedge clk); #1;
        end
        rst = 1'b0; rmask = 4'd0; wmask = 4'd0;
        repeat (4) begin @(posedge clk); #1; end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
